// File: rtl/fpga_data_source.sv
// CSR-loaded byte RAM streamed out as one AXI4-Stream packet per burst command.
// Software fills the RAM through CTRL write commands, then triggers a burst.
module fpga_data_source #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_write_n,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [7:0]  axis4_m_tdata,
  output logic        axis4_m_tvalid,
  output logic        axis4_m_tlast,
  input  logic        axis4_m_tready
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RDW, LOAD, SEND
  } state_t;

  state_t        state_q;
  logic [7:0]    mem [DEPTH];
  logic [31:0]   ctrl_q;
  logic [AW-1:0] start_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rem_q;
  logic [7:0]    len_q;
  logic [7:0]    ram_q;
  logic [7:0]    rdata_q;
  logic [7:0]    sent_q;
  logic          busy_q;
  logic          uf_q;
  logic [15:0]   count_q;
  logic [7:0]    tdata_q;
  logic          tvalid_q;
  logic          tlast_q;

  logic          csr_we;
  logic          ctrl_we;
  logic          cmd_v;
  logic [1:0]    cmd_t;
  logic [AW-1:0] cmd_a;
  logic [7:0]    cmd_d;
  logic [7:0]    cmd_l;
  logic          pend;
  logic          hs;
  logic [AW-1:0] ptr_d;

  assign csr_we  = avs_chipselect & ~avs_write_n;
  assign ctrl_we = csr_we && (avs_address == 2'd0);
  assign cmd_v   = ctrl_q[0];
  assign cmd_t   = ctrl_q[2:1];
  assign cmd_a   = ctrl_q[AW+7:8];
  assign cmd_d   = ctrl_q[23:16];
  assign cmd_l   = ctrl_q[31:24];
  // a queued command keeps busy high across the return to IDLE
  assign pend    = cmd_v && (cmd_t != 2'b11);
  assign hs      = tvalid_q & axis4_m_tready;
  assign ptr_d   = ptr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (state_q == WR) mem[addr_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      start_q  <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      ram_q    <= '0;
      rdata_q  <= '0;
      sent_q   <= '0;
      busy_q   <= 1'b0;
      uf_q     <= 1'b0;
      count_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      if (csr_we) begin
        unique case (avs_address)
          2'd0:    ctrl_q  <= avs_writedata;
          2'd2:    start_q <= avs_writedata[AW-1:0];
          default: ;
        endcase
      end
      unique case (state_q)
        IDLE: begin
          if (cmd_v) begin
            if (!ctrl_we) ctrl_q[0] <= 1'b0;
            unique case (cmd_t)
              2'b01: begin
                busy_q  <= 1'b1;
                addr_q  <= cmd_a;
                wdata_q <= cmd_d;
                state_q <= WR;
              end
              2'b00: begin
                busy_q  <= 1'b1;
                addr_q  <= cmd_a;
                state_q <= RD;
              end
              2'b10: begin
                busy_q  <= 1'b1;
                ptr_q   <= start_q;
                rem_q   <= cmd_l;
                len_q   <= cmd_l + 8'd1;
                uf_q    <= int'(cmd_l) >= DEPTH;
                state_q <= LOAD;
              end
              default: ;
            endcase
          end
        end
        WR: begin
          busy_q  <= pend;
          state_q <= IDLE;
        end
        RD: begin
          ram_q   <= mem[addr_q];
          state_q <= RDW;
        end
        RDW: begin
          rdata_q <= ram_q;
          busy_q  <= pend;
          state_q <= IDLE;
        end
        LOAD: begin
          tdata_q  <= mem[ptr_q];
          tvalid_q <= 1'b1;
          tlast_q  <= (rem_q == 8'd0);
          state_q  <= SEND;
        end
        SEND: begin
          if (hs) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              sent_q   <= len_q;
              count_q  <= count_q + 16'd1;
              busy_q   <= pend;
              state_q  <= IDLE;
            end else begin
              ptr_q   <= ptr_d;
              rem_q   <= rem_q - 8'd1;
              tdata_q <= mem[ptr_d];
              tlast_q <= (rem_q == 8'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    avs_readdata = '0;
    unique case (avs_address)
      2'd0: avs_readdata = ctrl_q;
      2'd1: avs_readdata = {sent_q, 7'd0, uf_q,
                            rdata_q, 7'd0, busy_q};
      2'd2: avs_readdata = {{(32-AW){1'b0}}, start_q};
      2'd3: avs_readdata = {16'd0, count_q};
      default: ;
    endcase
  end

  assign axis4_m_tdata  = tdata_q;
  assign axis4_m_tvalid = tvalid_q;
  assign axis4_m_tlast  = tlast_q;

endmodule

// File: tb/tb_fpga_data_source.sv
// Random and directed checks of fpga_data_source against a
// byte-array reference of the RAM and CSR counters.
module tb_fpga_data_source;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [7:0]  axis4_m_tdata;
  logic        axis4_m_tvalid;
  logic        axis4_m_tlast;
  logic        axis4_m_tready;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mem_m [32];
  int         count_m = 0;

  fpga_data_source #(.DEPTH(32), .AW(5)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_write_n    (avs_write_n),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .axis4_m_tdata  (axis4_m_tdata),
    .axis4_m_tvalid (axis4_m_tvalid),
    .axis4_m_tlast  (axis4_m_tlast),
    .axis4_m_tready (axis4_m_tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrl_word(input int t, input int a,
                                            input int d, input int l);
    return (32'(l & 255) << 24) | (32'(d & 255) << 16) |
           (32'(a & 31) << 8) | (32'(t & 3) << 1) | 32'd1;
  endfunction

  task automatic csr_wr(input int a, input logic [31:0] d);
    @(negedge clk);
    avs_address    = 2'(a);
    avs_writedata  = d;
    avs_chipselect = 1'b1;
    avs_write_n    = 1'b0;
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_write_n    = 1'b1;
  endtask

  task automatic csr_rd(input int a, output logic [31:0] d);
    @(negedge clk);
    avs_address    = 2'(a);
    avs_chipselect = 1'b1;
    #1 d = avs_readdata;
    avs_chipselect = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int k;
    for (k = 0; k < 50; k++) begin
      csr_rd(1, s);
      if (!s[0]) break;
    end
    if (k == 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_write(input int a, input int d);
    csr_wr(0, ctrl_word(1, a, d, 0));
    mem_m[a & 31] = 8'(d);
    wait_idle();
  endtask

  task automatic do_read(input int a);
    logic [31:0] s;
    s = '0;
    csr_wr(0, ctrl_word(0, a, 0, 0));
    for (int k = 0; k < 3; k++) begin
      csr_rd(1, s);
      if (!s[0]) break;
    end
    check("rd_busy", {31'd0, s[0]}, 32'd0);
    check("rd_data", {24'd0, s[15:8]}, {24'd0, mem_m[a & 31]});
  endtask

  // mode 0: tready high, 1: toggling 1010.., 2: random
  task automatic burst(input int st, input int lm1, input int mode,
                       input bit inj, input int ia, input int id);
    int idx, cyc, gaps;
    bit pv, done, seen, injd, r;
    logic [7:0] pd, ed;
    logic pl, el;
    logic [31:0] s;
    idx = 0; cyc = 0; gaps = 0;
    pv = 0; done = 0; seen = 0; injd = 0;
    pd = '0; pl = 1'b0;
    csr_wr(2, 32'(st));
    csr_wr(0, ctrl_word(2, 0, 0, lm1));
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      avs_chipselect = 1'b0;
      avs_write_n    = 1'b1;
      if (pv) begin
        check("hold_valid", {31'd0, axis4_m_tvalid}, 32'd1);
        check("hold_data", {24'd0, axis4_m_tdata}, {24'd0, pd});
        check("hold_last", {31'd0, axis4_m_tlast}, {31'd0, pl});
      end
      unique case (mode)
        0: r = 1'b1;
        1: r = (cyc % 2) == 1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      axis4_m_tready = r;
      if (axis4_m_tvalid && r) begin
        ed = mem_m[(st + idx) % 32];
        el = (idx == lm1);
        check("beat_data", {24'd0, axis4_m_tdata}, {24'd0, ed});
        check("beat_last", {31'd0, axis4_m_tlast}, {31'd0, el});
        done = (idx == lm1);
        idx++;
      end else if (mode == 0 && seen) begin
        gaps++;
      end
      if (axis4_m_tvalid) seen = 1;
      pv = axis4_m_tvalid && !r;
      pd = axis4_m_tdata;
      pl = axis4_m_tlast;
      if (inj && !injd && idx == 2) begin
        avs_address    = 2'd0;
        avs_writedata  = ctrl_word(1, ia, id, 0);
        avs_chipselect = 1'b1;
        avs_write_n    = 1'b0;
        injd = 1;
      end
    end
    if (!done) check("burst_timeout", 32'd1, 32'd0);
    if (mode == 0) check("burst_gaps", 32'(gaps), 32'd0);
    csr_rd(1, s);
    axis4_m_tready = 1'b0;
    check("end_valid", {31'd0, axis4_m_tvalid}, 32'd0);
    check("end_busy", {31'd0, s[0]}, {31'd0, inj});
    count_m = (count_m + 1) % 65536;
    if (inj) mem_m[ia & 31] = 8'(id);
    wait_idle();
    csr_rd(1, s);
    check("stat_sent", {24'd0, s[31:24]}, 32'((lm1 + 1) % 256));
    check("stat_uf", {31'd0, s[16]}, {31'd0, lm1 >= 32});
    csr_rd(3, s);
    check("count", s, 32'(count_m));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    int k;
    reset_n        = 1'b0;
    avs_address    = '0;
    avs_chipselect = 1'b0;
    avs_write_n    = 1'b1;
    avs_writedata  = '0;
    axis4_m_tready = 1'b0;
    for (int i = 0; i < 32; i++) mem_m[i] = 8'hxx;
    #1;
    check("rst_tvalid", {31'd0, axis4_m_tvalid}, 32'd0);
    check("rst_tlast", {31'd0, axis4_m_tlast}, 32'd0);
    check("rst_tdata", {24'd0, axis4_m_tdata}, 32'd0);
    for (int a = 0; a < 4; a++) begin
      csr_rd(a, s);
      check("rst_csr", s, 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) do_write(i, $urandom_range(0, 255));
    do_write(5, 8'hA5);
    do_read(5);

    do_write(0, 8'h11);
    do_write(1, 8'h22);
    do_write(2, 8'h33);
    do_write(3, 8'h44);
    burst(0, 3, 0, 0, 0, 0);
    burst(0, 3, 1, 0, 0, 0);
    burst(30, 3, 2, 0, 0, 0);
    burst(7, 40, 0, 0, 0, 0);
    burst(12, 9, 2, 1, 13, 8'h5C);
    do_read(13);

    for (int it = 0; it < 10; it++) begin
      k = $urandom_range(0, 2);
      if (k == 0) do_write($urandom_range(0, 31), $urandom_range(0, 255));
      else if (k == 1) do_read($urandom_range(0, 31));
      else burst($urandom_range(0, 31), $urandom_range(0, 47), 2, 0, 0, 0);
    end

    csr_wr(2, 32'd4);
    csr_wr(0, ctrl_word(2, 0, 0, 10));
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (axis4_m_tvalid) break;
    end
    check("pre_rst_valid", {31'd0, axis4_m_tvalid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, axis4_m_tvalid}, 32'd0);
    check("mid_rst_last", {31'd0, axis4_m_tlast}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    count_m = 0;
    for (int a = 0; a < 4; a++) begin
      csr_rd(a, s);
      check("post_rst_csr", s, 32'd0);
    end
    burst(2, 5, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
